uart_tx_serializer: RTL

- UART transmit stage sitting directly downstream of the APB subsystem TX FIFO (registered-output mode, FALL_THROUGH=0).
- Pops one word when idle and the FIFO is non-empty, then serializes it onto tx: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Bit timing comes from an internal programmable baud divider.
- Reports busy and a per-frame done pulse to the UART register block.

---
 rtl/uart_tx_serializer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer fed by a registered-output TX FIFO: start, LSB-first data, optional parity, 1/2 stop bits.
// Optional parity generation is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_en,
  input  logic                  parity_odd,
`endif
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  // state   | meaning
  // IDLE    | line high, pop FIFO when enabled and non-empty
  // LOAD    | FIFO word valid; capture word and frame settings
  // START   | start bit (low)
  // DATA    | data bits, LSB first
  // PARITY  | parity bit (only with UART_TX_PARITY_EN)
  // STOP    | one or two stop bits (high)
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;
`endif

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                  state;
  logic [DIV_WIDTH-1:0]    cnt;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [DATA_WIDTH-1:0]   shift;
  logic [IDX_W-1:0]        idx;
  logic                    stop2_q;
  logic                    stop_idx;
  logic                    tx_r;
  logic                    busy_r;
  logic                    done_r;
`ifdef UART_TX_PARITY_EN
  logic                    par_en_q;
  logic                    par_bit_q;
`endif

  logic [DIV_WIDTH-1:0]    eff_in;
  logic [DIV_WIDTH-1:0]    cnt_reload;
  logic                    bit_end;
  logic                    one_cycle;
  logic                    last_stop;

  assign eff_in     = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
  assign cnt_reload = div_q - DIV_WIDTH'(1);
  assign bit_end    = (cnt == '0);
  assign one_cycle  = (div_q == DIV_WIDTH'(1));
  assign last_stop  = (stop_idx == stop2_q);

  // Pop request is combinational so the FIFO word is valid during LOAD.
  assign fifo_rd_en = rst_n && (state == S_IDLE) && tx_en && !fifo_empty;

  assign tx      = tx_r;
  assign busy    = busy_r;
  assign tx_done = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_q     <= DIV_WIDTH'(1);
      shift     <= '0;
      idx       <= '0;
      stop2_q   <= 1'b0;
      stop_idx  <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_r <= 1'b1;
          if (fifo_rd_en) begin
            state  <= S_LOAD;
            busy_r <= 1'b1;
          end
        end

        S_LOAD: begin
          shift    <= fifo_data;
          div_q    <= eff_in;
          stop2_q  <= stop2;
          cnt      <= eff_in - DIV_WIDTH'(1);
          idx      <= '0;
          stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_q  <= parity_en;
          par_bit_q <= (^fifo_data) ^ parity_odd;
`endif
          tx_r     <= 1'b0;
          state    <= S_START;
        end

        S_START: begin
          if (bit_end) begin
            cnt   <= cnt_reload;
            tx_r  <= shift[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt   <= cnt_reload;
            shift <= shift >> 1;
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                tx_r  <= par_bit_q;
                state <= S_PARITY;
              end else begin
                tx_r     <= 1'b1;
                stop_idx <= 1'b0;
                done_r   <= one_cycle && !stop2_q;
                state    <= S_STOP;
              end
`else
              tx_r     <= 1'b1;
              stop_idx <= 1'b0;
              done_r   <= one_cycle && !stop2_q;
              state    <= S_STOP;
`endif
            end else begin
              idx  <= idx + IDX_W'(1);
              tx_r <= shift[1];
            end
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt      <= cnt_reload;
            tx_r     <= 1'b1;
            stop_idx <= 1'b0;
            done_r   <= one_cycle && !stop2_q;
            state    <= S_STOP;
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
`endif

        S_STOP: begin
          tx_r <= 1'b1;
          // done is registered, so it is raised on the edge entering the final stop cycle
          if (bit_end) begin
            if (last_stop) begin
              busy_r <= 1'b0;
              state  <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
              cnt      <= cnt_reload;
              done_r   <= one_cycle;
            end
          end else begin
            cnt    <= cnt - DIV_WIDTH'(1);
            done_r <= (cnt == DIV_WIDTH'(1)) && last_stop;
          end
        end

        default: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
